core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning the PE rows and L0 depth per kernel load.
REQ-002 SHALL have parameter col, default 8, meaning the PE columns used to size the kernel-settle gap.
REQ-003 SHALL have parameter addr_w, default 11, meaning the SRAM address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to run one tile.
REQ-007 SHALL have port w_base, input, addr_w bits: xmem base address of the kernel.
REQ-008 SHALL have port x_base, input, addr_w bits: xmem base address of the activations.
REQ-009 SHALL have port p_base, input, addr_w bits: pmem base address for the psums.
REQ-010 SHALL have port len, input, addr_w bits: the number of activation vectors.
REQ-011 SHALL have port cfg_acc, input, 1 bit: the accumulate request.
REQ-012 SHALL have port ofifo_valid, input, 1 bit: the core output FIFO holds a row.
REQ-013 SHALL have port inst, output, 34 bits: the core instruction word.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL use this inst field map:
- [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem.
- [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem.
- [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
REQ-017 SHALL drive inst from registers; the idle word is 34'h1800C0000 (CENs and WENs high, all other bits 0).
REQ-018 SHALL run the states IDLE->KLOAD->KPROP->KGAP->XLOAD->EXEC->DRAIN->DONE->IDLE.
REQ-019 SHALL latch all bases, len and cfg_acc when IDLE samples start=1; the first KLOAD word appears on the next cycle.
REQ-020 SHALL ignore start while busy.
REQ-021 KLOAD: row xmem reads (CEN_xmem=0, WEN_xmem=1) at w_base+i; l0_wr=1 one cycle after each read; lasts row+1 cycles.
REQ-022 KPROP: load=1 and l0_rd=1 for row cycles.
REQ-023 KGAP: idle word for row+col cycles.
REQ-024 XLOAD: len reads at x_base+i, with l0_wr delayed one cycle; lasts len+1 cycles.
REQ-025 EXEC: execute=1 and l0_rd=1 for len cycles.
REQ-026 DRAIN: on each cycle with ofifo_valid=1, assert ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+k and k++.
REQ-027 DRAIN SHALL exit after len writes and SHALL wait indefinitely while ofifo_valid=0.
REQ-028 DONE: done=1 for exactly one cycle with the idle word, then IDLE.
REQ-029 SHALL skip XLOAD, EXEC and DRAIN when len=0 (KGAP->DONE).
REQ-030 SHALL wrap all address arithmetic modulo 2^addr_w.
REQ-031 SHALL never assert CEN_xmem=0 and CEN_pmem=0 in the same cycle.
REQ-032 SHALL keep ififo_wr and ififo_rd at 0.

Reset
REQ-033 SHALL, on reset=0 at any time including mid-tile, immediately force state IDLE, inst=34'h1800C0000, busy=0, done=0, and clear all counters.
REQ-034 SHALL not resume an interrupted tile after reset is released.

Configuration
REQ-035 SHALL, with CORE_CTRL_ACC_EN defined, drive inst[33]=latched cfg_acc during DRAIN write cycles and 0 otherwise.
REQ-036 SHALL, without CORE_CTRL_ACC_EN, tie inst[33] to 0 and ignore cfg_acc.

Structure
REQ-037 SHALL place in package core_ctrl_pkg: the inst bit-position constants, the idle-word constant and the state enum.
REQ-038 SHALL use one sub-module, core_ctrl_agen: a loadable base+offset address counter with wrap, instantiated for xmem and for pmem.

Verification
REQ-039 Scenario: start with w_base=0, x_base=8, p_base=0, len=4, ofifo_valid=1 -> xmem addresses 0..7 then 8..11; pmem writes 0..3; done pulse; 8+1+8+16+5+4+4+1 cycles from start to done.
REQ-040 Scenario: len=0 -> no execute, no ofifo_rd and no pmem write; done follows KGAP.
REQ-041 Scenario: ofifo_valid held low for 10 DRAIN cycles -> inst stays idle, busy=1; writes resume in order when it goes high.
REQ-042 Scenario: x_base=2046, len=4 -> A_xmem sequence 2046, 2047, 0, 1.
REQ-043 Scenario: reset low during EXEC -> next observation shows inst=34'h1800C0000 and busy=0; a new start runs the full tile.
REQ-044 Scenario: cfg_acc=1 with and without CORE_CTRL_ACC_EN -> inst[33]=1 on DRAIN writes only in the macro build, always 0 otherwise.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core instruction sequencer: instruction-word bit map,
// the idle word and the sequencer state encoding.
package core_ctrl_pkg;

   localparam int INST_W     = 34;
   localparam int A_W        = 11;

   localparam int B_ACC      = 33;
   localparam int B_CEN_P    = 32;
   localparam int B_WEN_P    = 31;
   localparam int B_AP_LO    = 20;
   localparam int B_CEN_X    = 19;
   localparam int B_WEN_X    = 18;
   localparam int B_AX_LO    = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXEC     = 1;
   localparam int B_LOAD     = 0;

   localparam logic [INST_W-1:0] IDLE_WORD = 34'h1800C0000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KLOAD = 3'd1,
      S_KPROP = 3'd2,
      S_KGAP  = 3'd3,
      S_XLOAD = 3'd4,
      S_EXEC  = 3'd5,
      S_DRAIN = 3'd6,
      S_DONE  = 3'd7
   } state_t;

endpackage

// File: rtl/core_ctrl_agen.sv
// Loadable base+offset address counter. addr shows the address to issue this cycle;
// step advances the pointer past it, wrapping modulo 2^addr_w.
module core_ctrl_agen #(
   parameter int addr_w = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [addr_w-1:0] base,
   output logic [addr_w-1:0] addr
);

   logic [addr_w-1:0] ptr_r;

   assign addr = load ? base : ptr_r;

   // Pointer register: reload from base, or advance past the address just issued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r <= {addr_w{1'b0}};
      end else if (step) begin
         ptr_r <= addr + addr_w'(1'b1);
      end else if (load) begin
         ptr_r <= base;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/core_ctrl.sv
// Tile sequencer: kernel load, propagate, settle gap, activation load, execute, psum drain.
// Build macro CORE_CTRL_ACC_EN: forwards the latched cfg_acc onto inst[33] for psum writes.
module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int addr_w = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [addr_w-1:0] w_base,
   input  logic [addr_w-1:0] x_base,
   input  logic [addr_w-1:0] p_base,
   input  logic [addr_w-1:0] len,
   input  logic              cfg_acc,
   input  logic              ofifo_valid,
   output logic [33:0]       inst,
   output logic              busy,
   output logic              done
);

   localparam logic [addr_w-1:0] ZERO     = {addr_w{1'b0}};
   localparam logic [addr_w-1:0] ONE      = addr_w'(1'b1);
   localparam logic [addr_w-1:0] ROW_C    = addr_w'(row);
   localparam logic [addr_w-1:0] GAP_LAST = addr_w'(row + col - 1);

   state_t              state_r, nxt_state_s;
   logic [addr_w-1:0]   cnt_r, nxt_cnt_s;
   logic [addr_w-1:0]   len_r, x_base_r;
   logic [INST_W-1:0]   inst_r, word_s;
   logic                busy_r, done_r;
   logic                take_s, x_load_s, x_rd_s, p_wr_s, acc_bit_s;
   logic [addr_w-1:0]   x_ld_base_s, x_addr_s, p_addr_s;
   logic                l0_wr_s, l0_rd_s, exe_s, ld_s;

   assign take_s = (state_r == S_IDLE) && start;

`ifdef CORE_CTRL_ACC_EN
   logic acc_r;

   // Accumulate request captured with the rest of the tile parameters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r <= 1'b0;
      end else if (take_s) begin
         acc_r <= cfg_acc;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign acc_bit_s = acc_r;
`else
   logic unused_cfg_acc_s;
   assign unused_cfg_acc_s = cfg_acc;
   assign acc_bit_s        = 1'b0;
`endif

   core_ctrl_agen #(.addr_w(addr_w)) u_xagen (
      .clk   (clk),
      .reset (reset),
      .load  (x_load_s),
      .step  (x_rd_s),
      .base  (x_ld_base_s),
      .addr  (x_addr_s)
   );

   core_ctrl_agen #(.addr_w(addr_w)) u_pagen (
      .clk   (clk),
      .reset (reset),
      .load  (take_s),
      .step  (p_wr_s),
      .base  (p_base),
      .addr  (p_addr_s)
   );

   // Next state and phase counter; cnt_r indexes the word currently on inst.
   always_comb begin
      nxt_state_s = state_r;
      nxt_cnt_s   = cnt_r + ONE;
      x_load_s    = 1'b0;
      x_ld_base_s = x_base_r;
      p_wr_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            nxt_cnt_s = ZERO;
            if (start) begin
               nxt_state_s = S_KLOAD;
               x_load_s    = 1'b1;
               x_ld_base_s = w_base;
            end else begin
               nxt_state_s = S_IDLE;
            end
         end
         S_KLOAD: begin
            if (cnt_r == ROW_C) begin
               nxt_state_s = S_KPROP;
               nxt_cnt_s   = ZERO;
            end else begin
               nxt_state_s = S_KLOAD;
            end
         end
         S_KPROP: begin
            if (cnt_r == ROW_C - ONE) begin
               nxt_state_s = S_KGAP;
               nxt_cnt_s   = ZERO;
            end else begin
               nxt_state_s = S_KPROP;
            end
         end
         S_KGAP: begin
            if (cnt_r != GAP_LAST) begin
               nxt_state_s = S_KGAP;
            end else if (len_r == ZERO) begin
               nxt_state_s = S_DONE;
               nxt_cnt_s   = ZERO;
            end else begin
               nxt_state_s = S_XLOAD;
               nxt_cnt_s   = ZERO;
               x_load_s    = 1'b1;
            end
         end
         S_XLOAD: begin
            if (cnt_r == len_r) begin
               nxt_state_s = S_EXEC;
               nxt_cnt_s   = ZERO;
            end else begin
               nxt_state_s = S_XLOAD;
            end
         end
         S_EXEC: begin
            if (cnt_r == len_r - ONE) begin
               // In DRAIN the counter holds the number of psum writes already issued.
               nxt_state_s = S_DRAIN;
               p_wr_s      = ofifo_valid;
               nxt_cnt_s   = ofifo_valid ? ONE : ZERO;
            end else begin
               nxt_state_s = S_EXEC;
            end
         end
         S_DRAIN: begin
            if (cnt_r == len_r) begin
               nxt_state_s = S_DONE;
               nxt_cnt_s   = ZERO;
            end else if (ofifo_valid) begin
               nxt_state_s = S_DRAIN;
               p_wr_s      = 1'b1;
            end else begin
               nxt_state_s = S_DRAIN;
               nxt_cnt_s   = cnt_r;
            end
         end
         S_DONE: begin
            nxt_state_s = S_IDLE;
            nxt_cnt_s   = ZERO;
         end
         default: begin
            nxt_state_s = S_IDLE;
            nxt_cnt_s   = ZERO;
         end
      endcase
   end

   // Strobes of the word for the upcoming cycle, derived from the next state.
   always_comb begin
      x_rd_s  = 1'b0;
      l0_wr_s = 1'b0;
      l0_rd_s = 1'b0;
      exe_s   = 1'b0;
      ld_s    = 1'b0;
      case (nxt_state_s)
         S_KLOAD: begin
            x_rd_s  = (nxt_cnt_s < ROW_C);
            l0_wr_s = (nxt_cnt_s != ZERO);
         end
         S_KPROP: begin
            ld_s    = 1'b1;
            l0_rd_s = 1'b1;
         end
         S_XLOAD: begin
            x_rd_s  = (nxt_cnt_s < len_r);
            l0_wr_s = (nxt_cnt_s != ZERO);
         end
         S_EXEC: begin
            exe_s   = 1'b1;
            l0_rd_s = 1'b1;
         end
         default: begin
            x_rd_s  = 1'b0;
         end
      endcase
   end

   // Assemble the instruction word; unused address fields stay zero.
   always_comb begin
      word_s                   = IDLE_WORD;
      word_s[B_ACC]            = p_wr_s & acc_bit_s;
      word_s[B_CEN_P]          = ~p_wr_s;
      word_s[B_WEN_P]          = ~p_wr_s;
      word_s[B_AP_LO +: A_W]   = p_wr_s ? A_W'(p_addr_s) : {A_W{1'b0}};
      word_s[B_CEN_X]          = ~x_rd_s;
      word_s[B_WEN_X]          = 1'b1;
      word_s[B_AX_LO +: A_W]   = x_rd_s ? A_W'(x_addr_s) : {A_W{1'b0}};
      word_s[B_OFIFO_RD]       = p_wr_s;
      word_s[B_IFIFO_WR]       = 1'b0;
      word_s[B_IFIFO_RD]       = 1'b0;
      word_s[B_L0_RD]          = l0_rd_s;
      word_s[B_L0_WR]          = l0_wr_s;
      word_s[B_EXEC]           = exe_s;
      word_s[B_LOAD]           = ld_s;
   end

   // State, counters, latched tile parameters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= S_IDLE;
         cnt_r    <= ZERO;
         len_r    <= ZERO;
         x_base_r <= ZERO;
         inst_r   <= IDLE_WORD;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= nxt_state_s;
         cnt_r    <= nxt_cnt_s;
         inst_r   <= word_s;
         busy_r   <= (nxt_state_s != S_IDLE);
         done_r   <= (nxt_state_s == S_DONE);
         if (take_s) begin
            len_r    <= len;
            x_base_r <= x_base;
         end else begin
            len_r    <= len_r;
            x_base_r <= x_base_r;
         end
      end
   end

   assign inst = inst_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: per-cycle comparison of inst/busy/done against
// word sequences assembled from the phase descriptions and the inst field map.
module tb_core_ctrl;

   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int AW  = 11;
   localparam logic [33:0] IDLE = 34'h1800C0000;

`ifdef CORE_CTRL_ACC_EN
   localparam logic ACC_ON = 1'b1;
`else
   localparam logic ACC_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          cfg_acc = 1'b0;
   logic          ofifo_valid = 1'b1;
   logic [AW-1:0] w_base = '0, x_base = '0, p_base = '0, len = '0;
   logic [33:0]   inst;
   logic          busy, done;

   int n_cmp = 0;
   int n_err = 0;
   logic [33:0] exp_q[$];
   logic        vld_q[$];

   core_ctrl #(.row(ROW), .col(COL), .addr_w(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
      .p_base(p_base), .len(len), .cfg_acc(cfg_acc), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] mk(input logic xrd, input logic [AW-1:0] ax,
                                      input logic l0w, input logic l0r, input logic ld,
                                      input logic ex, input logic pw, input logic [AW-1:0] ap,
                                      input logic acc);
      logic [33:0] w;
      w        = IDLE;
      w[33]    = pw & acc & ACC_ON;
      w[32]    = ~pw;
      w[31]    = ~pw;
      w[30:20] = pw ? ap : 11'd0;
      w[19]    = ~xrd;
      w[17:7]  = xrd ? ax : 11'd0;
      w[6]     = pw;
      w[3]     = l0r;
      w[2]     = l0w;
      w[1]     = ex;
      w[0]     = ld;
      return w;
   endfunction

   task automatic push(input logic [33:0] w, input logic v);
      exp_q.push_back(w);
      vld_q.push_back(v);
   endtask

   task automatic build(input logic [AW-1:0] w, input logic [AW-1:0] x, input logic [AW-1:0] p,
                        input int n, input int hold, input logic acc);
      logic [AW-1:0] a;
      exp_q.delete();
      vld_q.delete();
      for (int i = 0; i <= ROW; i++) begin
         a = w + AW'(i);
         push(mk(i < ROW, a, i > 0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, acc), 1'b1);
      end
      for (int i = 0; i < ROW; i++) push(mk(1'b0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, acc), 1'b1);
      for (int i = 0; i < ROW + COL; i++) push(IDLE, 1'b1);
      if (n > 0) begin
         for (int i = 0; i <= n; i++) begin
            a = x + AW'(i);
            push(mk(i < n, a, i > 0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, acc), 1'b1);
         end
         for (int i = 0; i < n; i++) push(mk(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, acc), 1'b1);
         for (int i = 0; i < hold; i++) push(IDLE, 1'b0);
         for (int i = 0; i < n; i++) begin
            a = p + AW'(i);
            push(mk(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, acc), 1'b1);
         end
      end
      push(IDLE, 1'b1);
   endtask

   task automatic run(input string nm, input logic [AW-1:0] w, input logic [AW-1:0] x,
                      input logic [AW-1:0] p, input int n, input int hold, input logic acc);
      build(w, x, p, n, hold, acc);
      @(negedge clk);
      w_base = w; x_base = x; p_base = p; len = AW'(n); cfg_acc = acc;
      start = 1'b1; ofifo_valid = vld_q[0];
      @(negedge clk);
      start = 1'b0;
      w_base = 11'h155; x_base = 11'h2AA; p_base = 11'h3C3; len = 11'd7; cfg_acc = ~acc;
      for (int k = 0; k < exp_q.size(); k++) begin
         check_eq($sformatf("%s_inst[%0d]", nm, k), 64'(inst), 64'(exp_q[k]));
         check_eq($sformatf("%s_busy[%0d]", nm, k), 64'(busy), 64'd1);
         check_eq($sformatf("%s_done[%0d]", nm, k), 64'(done), 64'(k == exp_q.size() - 1));
         ofifo_valid = (k + 1 < exp_q.size()) ? vld_q[k + 1] : 1'b1;
         start = (k == 20);
         @(negedge clk);
      end
      start = 1'b0;
      check_eq({nm, "_post_inst"}, 64'(inst), 64'(IDLE));
      check_eq({nm, "_post_busy"}, 64'(busy), 64'd0);
      check_eq({nm, "_post_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_inst", 64'(inst), 64'(IDLE));
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("idle_inst", 64'(inst), 64'(IDLE));
      check_eq("idle_busy", 64'(busy), 64'd0);

      run("base", 11'd0,    11'd8,    11'd0,    4, 0,  1'b0);
      run("len0", 11'd0,    11'd8,    11'd0,    0, 0,  1'b0);
      run("hold", 11'd16,   11'd32,   11'd100,  4, 10, 1'b0);
      run("wrap", 11'd2044, 11'd2046, 11'd2045, 4, 0,  1'b0);
      run("acc",  11'd0,    11'd8,    11'd0,    4, 0,  1'b1);

      // Reset in the middle of EXEC, then confirm the tile does not resume.
      @(negedge clk);
      w_base = 11'd0; x_base = 11'd8; p_base = 11'd0; len = 11'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_inst", 64'(inst), 64'(IDLE));
      check_eq("mid_rst_busy", 64'(busy), 64'd0);
      check_eq("mid_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq($sformatf("no_resume_inst[%0d]", k), 64'(inst), 64'(IDLE));
         check_eq($sformatf("no_resume_busy[%0d]", k), 64'(busy), 64'd0);
      end
      run("rerun", 11'd0, 11'd8, 11'd0, 4, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
